// File: rtl/fft2d_in_packer.sv
// fft2d_in_packer: packs a serial complex sample stream into 4-lane beats,
// buffers whole frames in a ping-pong bank pair and streams them to the FFT core.
// Optional macro FFT2D_IN_BITREV_EN: beats are read out in bit-reversed order.
`ifndef SFP_WIDTH
`define SFP_WIDTH 16
`endif

module fft2d_in_packer #(
   parameter int SfpWidth   = `SFP_WIDTH,
   parameter int FrameBeats = 64,
   parameter int BeatWidth  = $clog2(FrameBeats)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [SfpWidth-1:0]   s_re_i,
   input  logic [SfpWidth-1:0]   s_im_i,
   input  logic                  s_last_i,
   input  logic                  fft_idle_i,
   output logic                  start_o,
   output logic [4*SfpWidth-1:0] dr_o,
   output logic [4*SfpWidth-1:0] di_o,
   output logic                  frame_err_o,
   output logic [15:0]           frames_o
);

   localparam int CntWidth = BeatWidth + 2;
   localparam logic [CntWidth-1:0]  CntLast  = {CntWidth{1'b1}};
   localparam logic [BeatWidth-1:0] BeatLast = {BeatWidth{1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      START,
      STREAM
   } rd_state_e;

   // frame storage: bank, beat, lane
   logic [SfpWidth-1:0] mem_re_q [2][FrameBeats][4];
   logic [SfpWidth-1:0] mem_im_q [2][FrameBeats][4];

   // write side state
   logic                rdy_en_q, rdy_en_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                wr_bank_q, wr_bank_d;
   logic [1:0]          full_q, full_d;
   logic                err_q, err_d;
   logic [1:0]          set_full;
   logic                xfer;
   logic [BeatWidth-1:0] wr_beat;
   logic [1:0]          wr_lane;

   // read side state
   rd_state_e            state_q, state_d;
   logic [BeatWidth-1:0] beat_q, beat_d;
   logic                 rd_bank_q, rd_bank_d;
   logic [15:0]          frames_q, frames_d;
   logic [4*SfpWidth-1:0] dr_q, dr_d;
   logic [4*SfpWidth-1:0] di_q, di_d;
   logic [1:0]           clr_full;
   logic                 load_en;
   logic [BeatWidth-1:0] nxt_beat;
   logic [BeatWidth-1:0] rd_addr;
   logic [4*SfpWidth-1:0] rd_re;
   logic [4*SfpWidth-1:0] rd_im;

   assign s_ready_o   = rdy_en_q & ~full_q[wr_bank_q];
   assign xfer        = s_valid_i & s_ready_o;
   assign wr_beat     = cnt_q[CntWidth-1:2];
   assign wr_lane     = cnt_q[1:0];
   assign start_o     = (state_q == START);
   assign dr_o        = dr_q;
   assign di_o        = di_q;
   assign frame_err_o = err_q;
   assign frames_o    = frames_q;

   // sample counter, bank toggle and framing-error detection
   always_comb begin
      rdy_en_d  = 1'b1;
      cnt_d     = cnt_q;
      wr_bank_d = wr_bank_q;
      err_d     = 1'b0;
      set_full  = 2'b00;
      if (xfer) begin
         if (cnt_q == CntLast) begin
            set_full[wr_bank_q] = 1'b1;
            wr_bank_d = ~wr_bank_q;
            cnt_d     = '0;
            err_d     = ~s_last_i;
         end else if (s_last_i) begin
            cnt_d = '0;
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // bank full flags: writer sets, reader clears; never the same bank at once
   always_comb begin
      full_d = (full_q | set_full) & ~clr_full;
   end

   // sample write into the active bank
   always_ff @(posedge clk_i) begin
      if (xfer) begin
         mem_re_q[wr_bank_q][wr_beat][wr_lane] <= s_re_i;
         mem_im_q[wr_bank_q][wr_beat][wr_lane] <= s_im_i;
      end
   end

   // beat to be loaded into the output register this cycle
   always_comb begin
      nxt_beat = '0;
      if (state_q == STREAM) begin
         nxt_beat = beat_q + 1'b1;
      end
   end

`ifdef FFT2D_IN_BITREV_EN
   // bit-reversed beat address
   always_comb begin
      rd_addr = '0;
      for (int i = 0; i < BeatWidth; i++) begin
         rd_addr[i] = nxt_beat[BeatWidth-1-i];
      end
   end
`else
   // natural beat address
   always_comb begin
      rd_addr = nxt_beat;
   end
`endif

   // gather the four lanes of the selected beat
   always_comb begin
      rd_re = '0;
      rd_im = '0;
      for (int i = 0; i < 4; i++) begin
         rd_re[i*SfpWidth +: SfpWidth] = mem_re_q[rd_bank_q][rd_addr][i];
         rd_im[i*SfpWidth +: SfpWidth] = mem_im_q[rd_bank_q][rd_addr][i];
      end
   end

   // read FSM: wait for a full bank, pulse start, stream contiguous beats
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      rd_bank_d = rd_bank_q;
      frames_d  = frames_q;
      clr_full  = 2'b00;
      load_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (full_q[rd_bank_q] && fft_idle_i) begin
               state_d = START;
            end
         end
         START: begin
            state_d = STREAM;
            beat_d  = '0;
            load_en = 1'b1;
         end
         STREAM: begin
            if (beat_q == BeatLast) begin
               clr_full[rd_bank_q] = 1'b1;
               rd_bank_d = ~rd_bank_q;
               frames_d  = frames_q + 16'd1;
               beat_d    = '0;
               state_d   = IDLE;
            end else begin
               beat_d  = beat_q + 1'b1;
               load_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      dr_d = load_en ? rd_re : '0;
      di_d = load_en ? rd_im : '0;
   end

   // control and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdy_en_q  <= 1'b0;
         cnt_q     <= '0;
         wr_bank_q <= 1'b0;
         full_q    <= 2'b00;
         err_q     <= 1'b0;
         state_q   <= IDLE;
         beat_q    <= '0;
         rd_bank_q <= 1'b0;
         frames_q  <= '0;
         dr_q      <= '0;
         di_q      <= '0;
      end else begin
         rdy_en_q  <= rdy_en_d;
         cnt_q     <= cnt_d;
         wr_bank_q <= wr_bank_d;
         full_q    <= full_d;
         err_q     <= err_d;
         state_q   <= state_d;
         beat_q    <= beat_d;
         rd_bank_q <= rd_bank_d;
         frames_q  <= frames_d;
         dr_q      <= dr_d;
         di_q      <= di_d;
      end
   end

endmodule

// File: tb/tb_fft2d_in_packer.sv
// tb_fft2d_in_packer: directed and randomized stimulus for fft2d_in_packer,
// checked against a frame-level queue model of the expected beat stream.
module tb_fft2d_in_packer;

   localparam int W   = 16;
   localparam int FB  = 64;
   localparam int NPT = 4 * FB;

   logic           clk_i = 1'b0;
   logic           rst_ni = 1'b0;
   logic           s_valid_i = 1'b0;
   logic           s_ready_o;
   logic [W-1:0]   s_re_i = '0;
   logic [W-1:0]   s_im_i = '0;
   logic           s_last_i = 1'b0;
   logic           fft_idle_i = 1'b1;
   logic           start_o;
   logic [4*W-1:0] dr_o;
   logic [4*W-1:0] di_o;
   logic           frame_err_o;
   logic [15:0]    frames_o;

   int checks = 0;
   int errors = 0;

   fft2d_in_packer #(
      .SfpWidth   (W),
      .FrameBeats (FB)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .s_valid_i   (s_valid_i),
      .s_ready_o   (s_ready_o),
      .s_re_i      (s_re_i),
      .s_im_i      (s_im_i),
      .s_last_i    (s_last_i),
      .fft_idle_i  (fft_idle_i),
      .start_o     (start_o),
      .dr_o        (dr_o),
      .di_o        (di_o),
      .frame_err_o (frame_err_o),
      .frames_o    (frames_o)
   );

   always #5 clk_i = ~clk_i;

   // reference model: samples of completed frames, in arrival order
   logic [W-1:0] cur_re[$];
   logic [W-1:0] cur_im[$];
   logic [W-1:0] exp_re[$];
   logic [W-1:0] exp_im[$];
   int seq = 0;
   int exp_ptr = 0;
   int exp_err = 0;
   int n_total = 0;
   int n_queued = 0;

   // observed beats captured after each start pulse
   logic [4*W-1:0] obs_dr[$];
   logic [4*W-1:0] obs_di[$];
   int obs_ptr = 0;
   int n_start = 0;
   int n_err = 0;
   int nz_out = 0;
   int overlap = 0;
   int cap_left = 0;
   int base_idx = 0;

   initial begin
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            cap_left = 0;
            while (obs_dr.size() > base_idx) begin
               void'(obs_dr.pop_back());
               void'(obs_di.pop_back());
            end
         end else begin
            if (cap_left > 0) begin
               obs_dr.push_back(dr_o);
               obs_di.push_back(di_o);
               cap_left--;
               if (cap_left == 0) base_idx = obs_dr.size();
               if (start_o) overlap++;
            end else begin
               if (dr_o != '0 || di_o != '0) nz_out++;
               if (start_o) begin
                  n_start++;
                  cap_left = FB;
               end
            end
            if (frame_err_o) n_err++;
         end
      end
   end

   function automatic int brev(input int b);
`ifdef FFT2D_IN_BITREV_EN
      int r;
      int x;
      r = 0;
      x = b;
      for (int k = 0; k < $clog2(FB); k++) begin
         r = r * 2 + x % 2;
         x = x / 2;
      end
      return r;
`else
      return b;
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic model_accept(input logic [W-1:0] re, input logic [W-1:0] im,
                               input logic last);
      cur_re.push_back(re);
      cur_im.push_back(im);
      if (cur_re.size() == NPT) begin
         foreach (cur_re[k]) begin
            exp_re.push_back(cur_re[k]);
            exp_im.push_back(cur_im[k]);
         end
         cur_re.delete();
         cur_im.delete();
         if (!last) exp_err++;
         n_total++;
         n_queued++;
      end else if (last) begin
         cur_re.delete();
         cur_im.delete();
         exp_err++;
      end
   endtask

   task automatic send(input int n, input int last_at, input int pct);
      int tries;
      logic acc;
      for (int j = 0; j < n; j++) begin
         s_re_i   = 16'(seq);
         s_im_i   = 16'(-seq);
         s_last_i = (j == last_at);
         acc      = 1'b0;
         tries    = 0;
         while (!acc && tries < 3000) begin
            s_valid_i = (int'($urandom_range(99)) < pct);
            @(negedge clk_i);
            acc = s_valid_i && s_ready_o;
            @(posedge clk_i);
            #1;
            tries++;
         end
         if (!acc) begin
            chk("send_timeout", 64'(acc), 64'(1));
            s_valid_i = 1'b0;
            s_last_i  = 1'b0;
            return;
         end
         model_accept(s_re_i, s_im_i, s_last_i);
         seq++;
      end
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
   endtask

   task automatic check_frames(input int nf);
      int t;
      int eb;
      logic [4*W-1:0] er;
      logic [4*W-1:0] ei;
      t = 0;
      while (obs_dr.size() < obs_ptr + nf * FB && t < 20000) begin
         tick(1);
         t++;
      end
      chk("beats_avail", 64'(obs_dr.size() >= obs_ptr + nf * FB), 64'(1));
      for (int f = 0; f < nf; f++) begin
         for (int b = 0; b < FB; b++) begin
            eb = brev(b);
            for (int i = 0; i < 4; i++) begin
               er[i*W +: W] = exp_re[exp_ptr + 4 * eb + i];
               ei[i*W +: W] = exp_im[exp_ptr + 4 * eb + i];
            end
            if (obs_ptr < obs_dr.size()) begin
               chk($sformatf("beat_re f%0d b%0d", f, b), obs_dr[obs_ptr], er);
               chk($sformatf("beat_im f%0d b%0d", f, b), obs_di[obs_ptr], ei);
            end
            obs_ptr++;
         end
         exp_ptr += NPT;
      end
   endtask

   initial begin
      int t;
      // reset state
      tick(3);
      chk("rst_ready", 64'(s_ready_o), 64'(0));
      chk("rst_start", 64'(start_o), 64'(0));
      chk("rst_dr", dr_o, 64'(0));
      chk("rst_di", di_o, 64'(0));
      chk("rst_err", 64'(frame_err_o), 64'(0));
      chk("rst_frames", 64'(frames_o), 64'(0));
      rst_ni = 1'b1;
      tick(1);
      chk("ready_after_rst", 64'(s_ready_o), 64'(1));

      // single frame, latency of the start pulse
      fft_idle_i = 1'b1;
      send(NPT, NPT - 1, 100);
      chk("t1_start_early", 64'(start_o), 64'(0));
      tick(1);
      chk("t1_start_lat", 64'(start_o), 64'(1));
      check_frames(1);
      tick(4);
      chk("t1_frames", 64'(frames_o), 64'(n_queued));
      chk("t1_starts", 64'(n_start), 64'(n_total));

      // both banks fill while the core is busy
      fft_idle_i = 1'b0;
      send(NPT, NPT - 1, 100);
      send(NPT, NPT - 1, 100);
      tick(2);
      chk("t2_ready_low", 64'(s_ready_o), 64'(0));
      chk("t2_no_start", 64'(n_start), 64'(n_total - 2));
      fft_idle_i = 1'b1;
      send(NPT, NPT - 1, 100);
      check_frames(3);
      tick(4);
      chk("t2_frames", 64'(frames_o), 64'(n_queued));
      chk("t2_ready_back", 64'(s_ready_o), 64'(1));

      // early s_last drops the partial frame
      send(101, 100, 100);
      tick(3);
      chk("t3_err", 64'(n_err), 64'(exp_err));
      chk("t3_no_start", 64'(n_start), 64'(n_total));
      send(NPT, NPT - 1, 100);
      check_frames(1);
      tick(4);
      chk("t3_frames", 64'(frames_o), 64'(n_queued));

      // reset in the middle of a stream
      send(NPT, NPT - 1, 100);
      t = 0;
      while (n_start < n_total && t < 500) begin
         tick(1);
         t++;
      end
      chk("t4_started", 64'(n_start), 64'(n_total));
      tick(30);
      rst_ni = 1'b0;
      #1;
      chk("t4_rst_dr", dr_o, 64'(0));
      chk("t4_rst_di", di_o, 64'(0));
      chk("t4_rst_start", 64'(start_o), 64'(0));
      chk("t4_rst_frames", 64'(frames_o), 64'(0));
      chk("t4_rst_ready", 64'(s_ready_o), 64'(0));
      exp_ptr += NPT;
      n_queued = 0;
      tick(3);
      rst_ni = 1'b1;
      tick(300);
      chk("t4_no_start", 64'(n_start), 64'(n_total));
      chk("t4_frames", 64'(frames_o), 64'(0));
      chk("t4_ready", 64'(s_ready_o), 64'(1));

      // random valid over four frames
      for (int f = 0; f < 4; f++) begin
         send(NPT, NPT - 1, 50);
      end
      check_frames(4);
      tick(4);
      chk("t5_frames", 64'(frames_o), 64'(n_queued));
      chk("t5_err", 64'(n_err), 64'(exp_err));
      chk("t5_starts", 64'(n_start), 64'(n_total));
      chk("nz_outside", 64'(nz_out), 64'(0));
      chk("overlap", 64'(overlap), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
